// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: per-bit logic unit with an XOR accumulator behind a
// single valid/ready output register stage.
//
// Parameters:
//   WIDTH      operand / result width in bits (1..64)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream operation valid
//   in_ready   block can accept an operation this cycle
//   a, b       operands
//   op         000 AND, 001 OR, 010 XOR, 011 NOR,
//              100 ACC_XOR, 101 ACC_READ, 11x reserved
//   acc_clr    synchronous accumulator clear, independent of handshake
//   out_valid  registered result valid
//   out_ready  downstream accepts the result
//   res        registered result
//   zero       registered flag, res is all zeros
//   err        registered flag, the op was reserved
module bitwise_logic_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             err
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_xor;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             err_nxt;
    logic             accept;

    logic is_and;
    logic is_or;
    logic is_xor;
    logic is_nor;
    logic is_accx;
    logic is_accr;

    // One output stage: a new op may enter whenever the slot is empty
    // or is being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign is_and  = (op == 3'b000);
    assign is_or   = (op == 3'b001);
    assign is_xor  = (op == 3'b010);
    assign is_nor  = (op == 3'b011);
    assign is_accx = (op == 3'b100);
    assign is_accr = (op == 3'b101);

    // The clear takes effect before a coincident ACC_XOR folds in,
    // while ACC_READ still sees the pre-clear value.
    assign acc_base = acc_clr ? '0 : acc;
    assign acc_xor  = acc_base ^ a ^ b;

    always_comb begin
        res_nxt = '0;
        err_nxt = 1'b0;
        unique case (1'b1)
            is_and:  res_nxt = a & b;
            is_or:   res_nxt = a | b;
            is_xor:  res_nxt = a ^ b;
            is_nor:  res_nxt = ~(a | b);
            is_accx: res_nxt = acc_xor;
            is_accr: res_nxt = acc;
            default: err_nxt = 1'b1;
        endcase
    end

    assign acc_nxt = (accept && is_accx) ? acc_xor : acc_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res       <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            res       <= res_nxt;
            zero      <= ~|res_nxt;
            err       <= err_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb_bitwise_logic_pipe: directed and random checks of bitwise_logic_pipe
// against a cycle-level behavioural model of the handshake and accumulator.
module tb_bitwise_logic_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         zero;
    logic         err;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [W-1:0] m_acc;
    logic         m_valid;
    logic [W-1:0] m_res;
    logic         m_zero;
    logic         m_err;

    bitwise_logic_pipe #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .op(op),
        .acc_clr(acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res(res),
        .zero(zero),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_result(
        input logic [2:0] o, input logic [W-1:0] x,
        input logic [W-1:0] y, input logic clr, input logic [W-1:0] ac);
        logic [W-1:0] base;
        base = clr ? '0 : ac;
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return base ^ x ^ y;
            3'd5: return ac;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_acc   = '0;
        m_valid = 1'b0;
        m_res   = '0;
        m_zero  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One cycle: drive at negedge, check in_ready, clock, check outputs.
    task automatic step(input logic iv, input logic [2:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic clr, input logic ordy);
        logic acc_ok;
        logic exp_rdy;
        logic [W-1:0] r;
        in_valid  = iv;
        op        = o;
        a         = x;
        b         = y;
        acc_clr   = clr;
        out_ready = ordy;
        #1;
        exp_rdy = !m_valid || ordy;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
        end
        acc_ok = iv && exp_rdy;
        r = model_result(o, x, y, clr, m_acc);
        if (acc_ok) begin
            m_valid = 1'b1;
            m_res   = r;
            m_zero  = (r == '0);
            m_err   = (o >= 3'd6);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (acc_ok && o == 3'd4) m_acc = r;
        else if (clr) m_acc = '0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
        end
        checks++;
        if (res !== m_res) begin
            errors++;
            $display("FAIL res: got %h want %h", res, m_res);
        end
        checks++;
        if (zero !== m_zero || err !== m_err) begin
            errors++;
            $display("FAIL flags: got z=%b e=%b want z=%b e=%b",
                     zero, err, m_zero, m_err);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        op = 3'd4;
        a = 32'hFFFF_FFFF;
        b = '0;
        acc_clr = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || res !== '0 || zero !== 1'b0
            || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%h z=%b e=%b rdy=%b want 0 0 0 0 1",
                     out_valid, res, zero, err, in_ready);
        end
        rst_n = 1'b1;
        step(1'b1, 3'd5, '0, '0, 1'b0, 1'b1);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL reset_acc: got %h want 00000000", res);
        end
    endtask

    task automatic test_ops();
        logic [W-1:0] exp [4];
        exp[0] = 32'hF000_F000;
        exp[1] = 32'hFFF0_FFF0;
        exp[2] = 32'h0FF0_0FF0;
        exp[3] = 32'h000F_000F;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1);
            checks++;
            if (res !== exp[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL ops_%0d: got %h v=%b want %h v=1",
                         i, res, out_valid, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_accumulate();
        logic [W-1:0] exp [3];
        exp[0] = 32'h1;
        exp[1] = 32'h2;
        exp[2] = 32'h2;
        step(1'b0, 3'd0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 3'd4, 32'h1, '0, 1'b0, 1'b1);
        checks++;
        if (res !== exp[0]) begin
            errors++;
            $display("FAIL acc_0: got %h want %h", res, exp[0]);
        end
        step(1'b1, 3'd4, 32'h3, '0, 1'b0, 1'b1);
        checks++;
        if (res !== exp[1]) begin
            errors++;
            $display("FAIL acc_1: got %h want %h", res, exp[1]);
        end
        step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b1);
        checks++;
        if (res !== exp[2]) begin
            errors++;
            $display("FAIL acc_read: got %h want %h", res, exp[2]);
        end
        idle();
    endtask

    task automatic test_backpressure();
        step(1'b0, 3'd0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 3'd4, 32'h10, '0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 3'd4, 32'h10, '0, 1'b0, 1'b0);
        checks++;
        if (res !== 32'h10 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got %h rdy=%b want 00000010 rdy=0",
                     res, in_ready);
        end
        step(1'b1, 3'd5, '0, '0, 1'b0, 1'b1);
        checks++;
        if (res !== 32'h10) begin
            errors++;
            $display("FAIL bp_acc_once: got %h want 00000010", res);
        end
        idle();
    endtask

    task automatic test_clear_boundary();
        step(1'b0, 3'd0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 3'd4, 32'h1234_5678, '0, 1'b0, 1'b1);
        step(1'b1, 3'd4, 32'h0000_00FF, '0, 1'b1, 1'b1);
        checks++;
        if (res !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL clr_accx: got %h want 000000ff", res);
        end
        step(1'b1, 3'd0, '0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL and_zero: got %b want 1", zero);
        end
        // read coinciding with clear sees the pre-clear value
        step(1'b1, 3'd5, '0, '0, 1'b1, 1'b1);
        checks++;
        if (res !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL clr_read: got %h want 000000ff", res);
        end
        step(1'b1, 3'd5, '0, '0, 1'b0, 1'b1);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL after_clr: got %h want 00000000", res);
        end
        idle();
    endtask

    task automatic test_reserved();
        step(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        checks++;
        if (res !== '0 || zero !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL reserved: got r=%h z=%b e=%b want 0 1 1",
                     res, zero, err);
        end
        step(1'b1, 3'd7, 32'h5, 32'h6, 1'b0, 1'b1);
        step(1'b1, 3'd2, 32'h5, 32'h6, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b0 || res !== 32'h3) begin
            errors++;
            $display("FAIL after_reserved: got e=%b r=%h want 0 00000003",
                     err, res);
        end
        idle();
    endtask

    task automatic test_async_reset();
        step(1'b1, 3'd4, 32'hA5A5_0001, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || res !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v=%b r=%h rdy=%b want 0 0 1",
                     out_valid, res, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd5, '0, '0, 1'b0, 1'b1);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL reset_read: got %h want 00000000", res);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 W'($urandom), W'($urandom),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 2) != 0));
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'd4, W'(1 << i), '0, 1'b0, 1'b1);
        end
        step(1'b1, 3'd5, '0, '0, 1'b0, 1'b1);
        checks++;
        if (res !== (m_acc) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b: got %h v=%b want %h v=1", res, out_valid, m_acc);
        end
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ops();
        test_accumulate();
        test_backpressure();
        test_clear_boundary();
        test_reserved();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
